cache_controller: RTL and testbench
===================================

// Module: cache_controller
// PURPOSE
//  Sequences one direct-mapped, write-through, no-write-allocate cache between a CPU port and a backing memory.
//  Does tag lookup, line fill on read miss, write-through on every store, and in-cache update on store hit.
//  Owns all cache write_en/address/write_data; one request in flight.
// PARAMETERS
//  ADDR_WIDTH      8   byte-free word address width
//  DATA_WIDTH      32  word width
//  LOG_NUM_BLOCKS  1   log2 words per cache line (fill = 2**LOG_NUM_BLOCKS beats)
// PORTS
//  clk             in   1           single clock
//  rst             in   1           one clock; reset is asynchronous and active-low
//  cpu_req_valid   in   1           CPU request present
//  cpu_req_ready   out  1           controller accepts request (IDLE only)
//  cpu_req_we      in   1           1=store, 0=load
//  cpu_req_addr    in   ADDR_WIDTH  word address
//  cpu_req_wdata   in   DATA_WIDTH  store data
//  cpu_resp_valid  out  1           1-cycle completion pulse, no backpressure
//  cpu_resp_rdata  out  DATA_WIDTH  load data (0 for stores)
//  cpu_resp_hit    out  1           request hit in cache
//  cache_address   out  ADDR_WIDTH  cache lookup/write address
//  cache_write_en  out  1           cache write strobe
//  cache_write_data out DATA_WIDTH  cache write data
//  cache_hit       in   1           cache hit (combinational on cache_address)
//  cache_read_data in   DATA_WIDTH  cache async read data
//  mem_req_valid   out  1           memory request
//  mem_req_ready   in   1           memory accepts request (valid&&ready)
//  mem_req_we      out  1           memory write
//  mem_req_addr    out  ADDR_WIDTH  memory word address
//  mem_req_wdata   out  DATA_WIDTH  memory write data
//  mem_resp_valid  in   1           read data return
//  mem_resp_rdata  in   DATA_WIDTH  read data
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, cpu_req_ready=1, all other outputs 0, beat counter 0, latched req cleared.
//  IDLE: on cpu_req_valid&&cpu_req_ready latch we/addr/wdata -> LOOKUP.
//  LOOKUP (cache_address=latched addr):
//   load hit  -> register cache_read_data, -> RESP (resp 2 cycles after accept).
//   load miss -> FILL_REQ, beat=0.
//   store hit -> cache_write_en=1 this cycle with latched wdata; -> WRITE.
//   store miss -> WRITE, no cache write (no-write-allocate).
//  WRITE: mem_req_valid=1, we=1, addr/wdata latched; hold stable until mem_req_ready -> RESP.
//  FILL_REQ: mem_req_valid=1, we=0, addr={line base, beat}; hold until mem_req_ready -> FILL_WAIT.
//  FILL_WAIT: on mem_resp_valid: cache_write_en=1, cache_address={line base, beat}, data=mem_resp_rdata;
//   capture if beat==requested offset; last beat -> RESP, else beat+1 -> FILL_REQ.
//  RESP: cpu_resp_valid=1 one cycle, hit flag from LOOKUP; -> IDLE.
//  cpu_req_ready=1 only in IDLE; resp and new accept never in same cycle.
//  Beat counter LOG_NUM_BLOCKS wide, wraps to 0 after last beat; fill order always beat 0 upward.
//  mem_resp_valid outside FILL_WAIT ignored (incl. late return after mid-fill reset).
//  Reset mid-operation aborts: partial line may be in cache; no cpu_resp issued.
// CONFIGURATION
//  CACHE_CTRL_STATS_EN defined: extra outputs hit_count, miss_count (16b each).
//   Both increment at the LOOKUP decision, saturate at 0xFFFF, async reset to 0.
//  Undefined: ports and counters absent.
// STRUCTURE
//  cache_ctrl_pkg: state enum (IDLE,LOOKUP,WRITE,FILL_REQ,FILL_WAIT,RESP), STATS_WIDTH=16.
//  Sub-module cache_ctrl_fill_seq: beat counter, fill addr gen, last-beat flag.
// TESTING (ADDR_WIDTH=8, LOG_NUM_BLOCKS=1)
//  1 rst=0 mid-idle -> ready=1, resp_valid=0, mem_req_valid=0, cache_write_en=0 immediately.
//  2 load 0x14 miss, mem returns 0xAAAA0000@0x14, 0xBBBB0001@0x15 -> two mem reads, two cache writes, resp rdata=0xAAAA0000 hit=0.
//  3 then load 0x15 -> resp rdata=0xBBBB0001 hit=1, 2 cycles after accept, no mem_req_valid.
//  4 store 0x14=0x12345678 -> cache_write_en 1 cycle + mem write; mem_req_ready held 0 for 3 cycles keeps addr/data stable; later load 0x14 hit returns 0x12345678.
//  5 store 0x40 miss -> mem write only, cache_write_en never asserted, resp hit=0.
//  6 rst pulse in FILL_WAIT, then mem_resp_valid -> ignored; next load 0x20 served normally; STATS_EN build: counts match hits/misses.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared types for the direct-mapped write-through cache controller.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITE,
    FILL_REQ,
    FILL_WAIT,
    RESP
  } state_t;

  localparam int unsigned STATS_WIDTH = 16;

  // Saturating increment for the optional hit/miss counters
  function automatic logic [STATS_WIDTH-1:0] sat_inc(input logic [STATS_WIDTH-1:0] v);
    return (&v) ? v : v + STATS_WIDTH'(1);
  endfunction

endpackage

// File: rtl/cache_ctrl_fill_seq.sv
// Line-fill sequencer: beat counter, fill word address and last-beat flag.
module cache_ctrl_fill_seq #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned LOG_NUM_BLOCKS = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_clear,
  input  logic                                 i_advance,
  input  logic [ADDR_WIDTH-LOG_NUM_BLOCKS-1:0] i_line,
  output logic [LOG_NUM_BLOCKS-1:0]            o_beat,
  output logic [ADDR_WIDTH-1:0]                o_fill_addr,
  output logic                                 o_last
);

  logic [LOG_NUM_BLOCKS-1:0] r_beat;

  // Beats always run from 0 upward and wrap back to 0 after the last one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat <= '0;
    end else if (i_clear) begin
      r_beat <= '0;
    end else if (i_advance) begin
      r_beat <= r_beat + LOG_NUM_BLOCKS'(1);
    end
  end

  assign o_beat      = r_beat;
  assign o_fill_addr = {i_line, r_beat};
  assign o_last      = &r_beat;

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller, one request in flight.
// Optional hit/miss counters are built when CACHE_CTRL_STATS_EN is defined.
module cache_controller
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned LOG_NUM_BLOCKS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_req_we,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
  output logic                  cpu_resp_valid,
  output logic [DATA_WIDTH-1:0] cpu_resp_rdata,
  output logic                  cpu_resp_hit,
  output logic [ADDR_WIDTH-1:0] cache_address,
  output logic                  cache_write_en,
  output logic [DATA_WIDTH-1:0] cache_write_data,
  input  logic                  cache_hit,
  input  logic [DATA_WIDTH-1:0] cache_read_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0] hit_count,
  output logic [STATS_WIDTH-1:0] miss_count
`endif
);

  state_t                    r_state;
  logic                      r_we;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [DATA_WIDTH-1:0]     r_rdata;
  logic                      r_hit;

  logic [LOG_NUM_BLOCKS-1:0] w_beat;
  logic [ADDR_WIDTH-1:0]     w_fill_addr;
  logic                      w_last;
  logic                      w_is_target;

  cache_ctrl_fill_seq #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .LOG_NUM_BLOCKS(LOG_NUM_BLOCKS)
  ) u_fill_seq (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (r_state == LOOKUP),
    .i_advance  ((r_state == FILL_WAIT) && mem_resp_valid),
    .i_line     (r_addr[ADDR_WIDTH-1:LOG_NUM_BLOCKS]),
    .o_beat     (w_beat),
    .o_fill_addr(w_fill_addr),
    .o_last     (w_last)
  );

  assign w_is_target = (w_beat == r_addr[LOG_NUM_BLOCKS-1:0]);

  // Request sequencing; load data and hit flag are held for the response cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_hit   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cpu_req_valid) begin
            r_we    <= cpu_req_we;
            r_addr  <= cpu_req_addr;
            r_wdata <= cpu_req_wdata;
            r_rdata <= '0;
            r_hit   <= 1'b0;
            r_state <= LOOKUP;
          end
        end
        LOOKUP: begin
          r_hit <= cache_hit;
          if (r_we) begin
            r_state <= WRITE;
          end else if (cache_hit) begin
            r_rdata <= cache_read_data;
            r_state <= RESP;
          end else begin
            r_state <= FILL_REQ;
          end
        end
        WRITE:    if (mem_req_ready) r_state <= RESP;
        FILL_REQ: if (mem_req_ready) r_state <= FILL_WAIT;
        FILL_WAIT: begin
          if (mem_resp_valid) begin
            if (w_is_target) r_rdata <= mem_resp_rdata;
            r_state <= w_last ? RESP : FILL_REQ;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Kept apart from the write strobe: the cache's hit is combinational on this address
  always_comb begin
    cache_address = '0;
    if (r_state == LOOKUP)         cache_address = r_addr;
    else if (r_state == FILL_WAIT) cache_address = w_fill_addr;
  end

  always_comb begin
    cpu_req_ready    = (r_state == IDLE);
    cpu_resp_valid   = (r_state == RESP);
    cpu_resp_rdata   = '0;
    cpu_resp_hit     = 1'b0;
    cache_write_en   = 1'b0;
    cache_write_data = '0;
    mem_req_valid    = 1'b0;
    mem_req_we       = 1'b0;
    mem_req_addr     = '0;
    mem_req_wdata    = '0;
    case (r_state)
      LOOKUP: begin
        if (r_we && cache_hit) begin
          cache_write_en   = 1'b1;
          cache_write_data = r_wdata;
        end
      end
      WRITE: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = r_addr;
        mem_req_wdata = r_wdata;
      end
      FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = w_fill_addr;
      end
      FILL_WAIT: begin
        if (mem_resp_valid) begin
          cache_write_en   = 1'b1;
          cache_write_data = mem_resp_rdata;
        end
      end
      RESP: begin
        cpu_resp_rdata = r_rdata;
        cpu_resp_hit   = r_hit;
      end
      default: ;
    endcase
  end

`ifdef CACHE_CTRL_STATS_EN
  logic [STATS_WIDTH-1:0] r_hit_count;
  logic [STATS_WIDTH-1:0] r_miss_count;

  // Counted once per request, at the tag decision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (r_state == LOOKUP) begin
      if (cache_hit) r_hit_count  <= sat_inc(r_hit_count);
      else           r_miss_count <= sat_inc(r_miss_count);
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench: external per-word cache and memory, line-level reference model.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [7:0]  cpu_req_addr;
  logic [31:0] cpu_req_wdata;
  logic        cpu_resp_valid, cpu_resp_hit;
  logic [31:0] cpu_resp_rdata;
  logic [7:0]  cache_address;
  logic        cache_write_en, cache_hit;
  logic [31:0] cache_write_data, cache_read_data;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [7:0]  mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  cache_controller #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LOG_NUM_BLOCKS(1)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata), .cpu_resp_hit(cpu_resp_hit),
    .cache_address(cache_address), .cache_write_en(cache_write_en), .cache_write_data(cache_write_data),
    .cache_hit(cache_hit), .cache_read_data(cache_read_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
`ifdef CACHE_CTRL_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  // External cache array: 16 words, each tagged with address bits [7:4]
  bit        c_vld  [16];
  bit [3:0]  c_tag  [16];
  bit [31:0] c_data [16];
  assign cache_hit       = c_vld[cache_address[3:0]] && (c_tag[cache_address[3:0]] == cache_address[7:4]);
  assign cache_read_data = c_data[cache_address[3:0]];
  always @(posedge clk) begin
    if (cache_write_en) begin
      c_vld[cache_address[3:0]]  <= 1'b1;
      c_tag[cache_address[3:0]]  <= cache_address[7:4];
      c_data[cache_address[3:0]] <= cache_write_data;
    end
  end

  function automatic logic [31:0] mem_init(input logic [7:0] a);
    if (a == 8'h14) return 32'hAAAA_0000;
    if (a == 8'h15) return 32'hBBBB_0001;
    return {8'hC3, a, ~a, 8'h96};
  endfunction

  // Controls from the main process to the memory responder
  bit hold_resp = 1'b0;
  int stall_req = 0, stall_len = 0, inject_req = 0;

  // Memory: random ready, read data returned 0..2 cycles after the read handshake
  initial begin : mem_env
    logic [31:0] env_mem [256];
    bit          rd_hs, wr_hs, saw_valid, pend;
    logic [7:0]  hs_addr, pend_addr;
    logic [31:0] hs_data;
    int          pend_dly, stall, stall_ack, inject_ack;
    for (int a = 0; a < 256; a++) env_mem[a] = mem_init(8'(a));
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    pend = 1'b0; pend_dly = 0; pend_addr = '0; stall = 0; stall_ack = 0; inject_ack = 0;
    forever begin
      @(negedge clk);
      rd_hs     = mem_req_valid && mem_req_ready && !mem_req_we;
      wr_hs     = mem_req_valid && mem_req_ready &&  mem_req_we;
      saw_valid = mem_req_valid;
      hs_addr   = mem_req_addr;
      hs_data   = mem_req_wdata;
      @(posedge clk);
      #1;
      if (wr_hs) env_mem[hs_addr] = hs_data;
      if (rd_hs) begin pend = 1'b1; pend_addr = hs_addr; pend_dly = $urandom_range(0, 2); end
      mem_resp_valid = 1'b0;
      if (pend && !hold_resp) begin
        if (pend_dly == 0) begin
          mem_resp_valid = 1'b1; mem_resp_rdata = env_mem[pend_addr]; pend = 1'b0;
        end else pend_dly--;
      end
      if (inject_ack != inject_req) begin
        inject_ack = inject_req; pend = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEAD_BEEF;
      end
      if (stall_ack != stall_req) begin stall_ack = stall_req; stall = stall_len; end
      if (stall > 0) begin
        mem_req_ready = 1'b0;
        if (saw_valid) stall--;
      end else mem_req_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Reference model: memory image plus one resident line base per index
  logic [31:0] ref_mem [256];
  bit          ref_vld [8];
  bit   [3:0]  ref_tag [8];
  int          exp_hc = 0, exp_mc = 0;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Per-transaction observations gathered by tick()
  bit          exp_we = 1'b0;
  logic [7:0]  exp_addr = '0;
  logic [31:0] exp_wdata = '0;
  int          cnt_cw = 0, cnt_mr = 0, cnt_mw = 0, cw_idx = 0, mr_idx = 0;
  bit          prev_stall = 1'b0, prev_mwe = 1'b0;
  logic [7:0]  prev_maddr = '0;
  logic [31:0] prev_mwd = '0;

  // Advance one cycle and check every output that has a rule on this cycle
  task automatic tick();
    @(negedge clk);
    chk("resp_ready_excl", 32'(cpu_resp_valid && cpu_req_ready), 32'd0);
    if (prev_stall) begin
      chk("mreq_hold_valid", 32'(mem_req_valid), 32'd1);
      chk("mreq_hold_addr", 32'(mem_req_addr), 32'(prev_maddr));
      chk("mreq_hold_we", 32'(mem_req_we), 32'(prev_mwe));
      chk("mreq_hold_wdata", mem_req_wdata, prev_mwd);
    end
    prev_stall = mem_req_valid && !mem_req_ready;
    prev_maddr = mem_req_addr; prev_mwe = mem_req_we; prev_mwd = mem_req_wdata;
    if (cache_write_en) begin
      cnt_cw++;
      if (exp_we) begin
        chk("hit_cw_addr", 32'(cache_address), 32'(exp_addr));
        chk("hit_cw_data", cache_write_data, exp_wdata);
      end else begin
        chk("fill_cw_addr", 32'(cache_address), 32'({exp_addr[7:1], cw_idx[0]}));
        chk("fill_cw_data", cache_write_data, ref_mem[cache_address]);
        cw_idx++;
      end
    end
    if (mem_req_valid && mem_req_ready) begin
      if (mem_req_we) begin
        cnt_mw++;
        chk("mem_wr_addr", 32'(mem_req_addr), 32'(exp_addr));
        chk("mem_wr_data", mem_req_wdata, exp_wdata);
      end else begin
        cnt_mr++;
        chk("fill_rd_addr", 32'(mem_req_addr), 32'({exp_addr[7:1], mr_idx[0]}));
        mr_idx++;
      end
    end
  endtask

  function automatic bit ref_hit(input logic [7:0] a);
    return ref_vld[a[3:1]] && (ref_tag[a[3:1]] == a[7:4]);
  endfunction

  task automatic present(input bit we, input logic [7:0] a, input logic [31:0] wd);
    int w;
    w = 0;
    while (!cpu_req_ready && w < 50) begin tick(); w++; end
    chk("req_ready", 32'(cpu_req_ready), 32'd1);
    exp_we = we; exp_addr = a; exp_wdata = wd;
    cnt_cw = 0; cnt_mr = 0; cnt_mw = 0; cw_idx = 0; mr_idx = 0;
    cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_addr = a; cpu_req_wdata = wd;
    tick();
    cpu_req_valid = 1'b0; cpu_req_we = ~we; cpu_req_addr = 8'($urandom); cpu_req_wdata = $urandom;
    chk("ready_low_after_accept", 32'(cpu_req_ready), 32'd0);
  endtask

  task automatic do_req(input bit we, input logic [7:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output bit hit, output int lat);
    bit e_hit;
    e_hit = ref_hit(a);
    present(we, a, wd);
    lat = 1;
    while (!cpu_resp_valid && lat < 100) begin tick(); lat++; end
    chk("resp_seen", 32'(cpu_resp_valid), 32'd1);
    rd = cpu_resp_rdata; hit = cpu_resp_hit;
    chk("resp_hit", 32'(hit), 32'(e_hit));
    chk("resp_rdata", rd, we ? 32'd0 : ref_mem[a]);
    chk("cache_writes", 32'(cnt_cw), we ? 32'(e_hit) : (e_hit ? 32'd0 : 32'd2));
    chk("mem_reads", 32'(cnt_mr), (!we && !e_hit) ? 32'd2 : 32'd0);
    chk("mem_writes", 32'(cnt_mw), we ? 32'd1 : 32'd0);
    if (!we && e_hit) chk("hit_latency", 32'(lat), 32'd2);
    if (e_hit) exp_hc++; else exp_mc++;
`ifdef CACHE_CTRL_STATS_EN
    chk("hit_count", 32'(hit_count), 32'(exp_hc));
    chk("miss_count", 32'(miss_count), 32'(exp_mc));
`endif
    if (we) ref_mem[a] = wd;
    else if (!e_hit) begin ref_vld[a[3:1]] = 1'b1; ref_tag[a[3:1]] = a[7:4]; end
    tick();
    chk("resp_one_cycle", 32'(cpu_resp_valid), 32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    chk({tag, "_ready"}, 32'(cpu_req_ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(cpu_resp_valid), 32'd0);
    chk({tag, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, "_cache_we"}, 32'(cache_write_en), 32'd0);
    exp_hc = 0; exp_mc = 0;
    prev_stall = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] rd;
    bit          hit;
    int          lat, w;
    for (int a = 0; a < 256; a++) ref_mem[a] = mem_init(8'(a));
    cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cpu_req_ready), 32'd1);
    chk("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_cache_we", 32'(cache_write_en), 32'd0);
    rst = 1'b1;
    tick();

    do_req(1'b0, 8'h14, 32'd0, rd, hit, lat);
    chk("ld14_rdata", rd, 32'hAAAA_0000);
    chk("ld14_hit", 32'(hit), 32'd0);

    do_req(1'b0, 8'h15, 32'd0, rd, hit, lat);
    chk("ld15_rdata", rd, 32'hBBBB_0001);
    chk("ld15_hit", 32'(hit), 32'd1);
    chk("ld15_latency", 32'(lat), 32'd2);

    stall_len = 3; stall_req++;
    do_req(1'b1, 8'h14, 32'h1234_5678, rd, hit, lat);
    chk("st14_hit", 32'(hit), 32'd1);
    chk("st14_stalled", 32'(lat >= 6), 32'd1);
    do_req(1'b0, 8'h14, 32'd0, rd, hit, lat);
    chk("ld14_after_st", rd, 32'h1234_5678);
    chk("ld14_after_st_hit", 32'(hit), 32'd1);

    do_req(1'b1, 8'h40, 32'hCAFE_F00D, rd, hit, lat);
    chk("st40_hit", 32'(hit), 32'd0);
    chk("st40_no_cache_write", 32'(cnt_cw), 32'd0);

    pulse_reset("idle_rst");

    // Abort a fill while waiting for the first beat, then return the stale beat
    hold_resp = 1'b1;
    present(1'b0, 8'h30, 32'd0);
    w = 0;
    while (cnt_mr == 0 && w < 50) begin tick(); w++; end
    chk("abort_fill_started", 32'(cnt_mr), 32'd1);
    tick(); tick();
    pulse_reset("fill_rst");
    inject_req++;
    hold_resp = 1'b0;
    repeat (4) begin
      tick();
      chk("late_resp_cache_we", 32'(cache_write_en), 32'd0);
      chk("late_resp_no_cpu_resp", 32'(cpu_resp_valid), 32'd0);
      chk("late_resp_ready", 32'(cpu_req_ready), 32'd1);
    end
    do_req(1'b0, 8'h20, 32'd0, rd, hit, lat);
    chk("ld20_rdata", rd, 32'hC320_DF96);
    chk("ld20_hit", 32'(hit), 32'd0);

    for (int i = 0; i < 200; i++) begin
      bit         we;
      logic [7:0] a;
      we = ($urandom_range(0, 2) == 0);
      a  = 8'($urandom_range(0, 63));
      do_req(we, a, $urandom, rd, hit, lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
